// File: rtl/pulse_pair_sequencer_pkg.sv
// Shared types and constants for the pulse pair sequencer.
// Defines the default count width, the sequencer states and the channel encoding.
package pulse_pair_sequencer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_RUN_A  = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_RUN_B  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

endpackage

// File: rtl/pulse_pair_sequencer_counter.sv
// Loadable down-counter that saturates at zero.
// One instance is shared by both channels of the sequencer.
module load_down_counter #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             counter_clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero_c
);

    // Load wins over decrement; decrement holds once the count reaches zero.
    always_ff @(posedge counter_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/pulse_pair_sequencer.sv
// Runs the shared down-counter/comparator through channel A then channel B per run,
// turning comparator matches into per-channel hit pulses.
module pulse_pair_sequencer
    import pulse_pair_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             counter_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             repeat_en,
    input  logic [WIDTH-1:0] a_val,
    input  logic [WIDTH-1:0] b_val,
    input  logic [WIDTH-1:0] thresh,
    input  logic             comp,
    output logic [WIDTH-1:0] cmp_x,
    output logic [WIDTH-1:0] cmp_y,
    output logic [WIDTH-1:0] cmp_nz,
    output logic             cmp_en,
    output logic             chan,
    output logic             hit_a,
    output logic             hit_b,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;

    logic             cnt_load_c;
    logic             cnt_dec_c;
    logic             cnt_zero_c;
    logic [WIDTH-1:0] cnt_val_c;
    logic             b_exit_c;

    // Counter control and end-of-B detection, decoded from the current state.
    always_comb begin
        cnt_load_c = 1'b0;
        cnt_dec_c  = 1'b0;
        cnt_val_c  = a_lat;
        b_exit_c   = 1'b0;
        case (state)
            ST_LOAD_A: cnt_load_c = 1'b1;
            ST_RUN_A:  cnt_dec_c  = 1'b1;
            ST_LOAD_B: begin
                cnt_load_c = 1'b1;
                cnt_val_c  = b_lat;
                b_exit_c   = (b_lat == '0);
            end
            ST_RUN_B: begin
                cnt_dec_c = 1'b1;
                b_exit_c  = cnt_zero_c;
            end
            default: ;
        endcase
        if (abort) begin
            cnt_load_c = 1'b0;
            cnt_dec_c  = 1'b0;
        end
    end

    load_down_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .counter_clk (counter_clk),
        .reset       (reset),
        .load        (cnt_load_c),
        .dec         (cnt_dec_c),
        .load_val    (cnt_val_c),
        .count       (cmp_x),
        .zero_c      (cnt_zero_c)
    );

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge counter_clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            a_lat  <= '0;
            b_lat  <= '0;
            cmp_y  <= '0;
            cmp_nz <= '0;
            cmp_en <= 1'b0;
            chan   <= CH_A;
            hit_a  <= 1'b0;
            hit_b  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            hit_a <= cmp_en & comp & (chan == CH_A);
            hit_b <= cmp_en & comp & (chan == CH_B);
            done  <= 1'b0;
            if (abort) begin
                state  <= ST_IDLE;
                cmp_en <= 1'b0;
                busy   <= 1'b0;
                hit_a  <= 1'b0;
                hit_b  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            a_lat  <= a_val;
                            b_lat  <= b_val;
                            cmp_y  <= thresh;
                            cmp_nz <= a_val;
                            chan   <= CH_A;
                            busy   <= 1'b1;
                            state  <= ST_LOAD_A;
                        end
                    end
                    ST_LOAD_A: begin
                        if (a_lat == '0) begin
                            chan   <= CH_B;
                            cmp_nz <= b_lat;
                            state  <= ST_LOAD_B;
                        end else begin
                            cmp_en <= 1'b1;
                            state  <= ST_RUN_A;
                        end
                    end
                    ST_RUN_A: begin
                        // The zero count is presented for one cycle before leaving.
                        if (cnt_zero_c) begin
                            cmp_en <= 1'b0;
                            chan   <= CH_B;
                            cmp_nz <= b_lat;
                            state  <= ST_LOAD_B;
                        end
                    end
                    ST_LOAD_B, ST_RUN_B: begin
                        if (b_exit_c) begin
                            cmp_en <= 1'b0;
                            if (repeat_en) begin
                                a_lat  <= a_val;
                                b_lat  <= b_val;
                                cmp_y  <= thresh;
                                cmp_nz <= a_val;
                                chan   <= CH_A;
                                state  <= ST_LOAD_A;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_FINISH;
                            end
                        end else if (state == ST_LOAD_B) begin
                            cmp_en <= 1'b1;
                            state  <= ST_RUN_B;
                        end
                    end
                    ST_FINISH: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        cmp_en <= 1'b0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
